// File: rtl/chip8_loader.sv
// Program-image loader for the CHIP-8 interpreter: takes a framed byte stream
// from the UART, writes the payload into program memory and holds the CPU meanwhile.
module chip8_loader #(
  parameter int          ADDR_WIDTH     = 12,
  parameter int          DATA_WIDTH     = 8,
  parameter int          BASE_ADDR      = 512,
  parameter int          MEM_SIZE       = 4096,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_i,
  input  logic                  rx_i_v,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  busy
);

  // Handshake: rx_i is consumed on every cycle where rx_i_v is high; there is
  // no back-pressure, so the loader accepts a byte on every strobe.

  localparam int MAX_LEN = MEM_SIZE - BASE_ADDR;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN_H = 3'd1,
    S_LEN_L = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  sum;
  logic [19:0] tmo;
  logic [16:0] new_len;

  assign new_len = {1'b0, len[15:8], rx_i};
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      sum       <= '0;
      tmo       <= '0;
      we        <= 1'b0;
      waddr     <= ADDR_WIDTH'(BASE_ADDR);
      d         <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      we        <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      if (state == S_IDLE) tmo <= '0;
      else if (rx_i_v)     tmo <= '0;
      else                 tmo <= tmo + 20'd1;

      // A byte in the same cycle as the timeout wins over the timeout.
      if (rx_i_v) begin
        case (state)
          S_IDLE: begin
            if (rx_i == SYNC_BYTE) begin
              state    <= S_LEN_H;
              cpu_hold <= 1'b1;
              idx      <= '0;
              sum      <= '0;
            end
          end
          S_LEN_H: begin
            len[15:8] <= rx_i;
            state     <= S_LEN_L;
          end
          S_LEN_L: begin
            len[7:0] <= rx_i;
            if (new_len == 17'd0 || new_len > 17'(MAX_LEN)) begin
              load_err <= 1'b1;
              state    <= S_IDLE;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            we    <= 1'b1;
            waddr <= ADDR_WIDTH'(BASE_ADDR) + idx[ADDR_WIDTH-1:0];
            d     <= DATA_WIDTH'(rx_i);
            idx   <= idx + 16'd1;
            sum   <= sum + rx_i;
            if (idx + 16'd1 == len) state <= S_CSUM;
          end
          S_CSUM: begin
            if (rx_i == sum) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_err <= 1'b1;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE && tmo == 20'(TIMEOUT_CYCLES - 1)) begin
        load_err <= 1'b1;
        state    <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_chip8_loader.sv
// Directed bench for chip8_loader: stimulus pushes cycle-tagged expected writes
// and pulses into queues, a negedge monitor pops and compares them.
module tb_chip8_loader;

  localparam int TMO = 100;
  localparam logic [1:0] EV_DONE = 2'b01;
  localparam logic [1:0] EV_ERR  = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_i;
  logic        rx_i_v;
  logic        we;
  logic [11:0] waddr;
  logic [7:0]  d;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // write entry: {cycle[31:0], addr[11:0], data[7:0]}; event entry: {cycle, err, done}
  logic [51:0] exp_q[$];
  logic [33:0] ev_q[$];

  chip8_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .rx_i_v(rx_i_v),
    .we(we), .waddr(waddr), .d(d), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][51:20] < 32'(cyc)) begin
      check("write_missing", 64'(0), 64'(exp_q.pop_front()));
    end
    while (ev_q.size() > 0 && ev_q[0][33:2] < 32'(cyc)) begin
      check("pulse_missing", 64'(0), 64'(ev_q.pop_front()));
    end
    if (we) begin
      if (exp_q.size() == 0) check("write_unexpected", 64'({32'(cyc), waddr, d}), 64'(0));
      else check("write", 64'({32'(cyc), waddr, d}), 64'(exp_q.pop_front()));
    end
    if (load_done || load_err) begin
      if (ev_q.size() == 0) check("pulse_unexpected", 64'({32'(cyc), load_err, load_done}), 64'(0));
      else check("pulse", 64'({32'(cyc), load_err, load_done}), 64'(ev_q.pop_front()));
    end
  end

  // driver tasks: called at a negedge, byte is consumed at the next posedge
  task automatic send(input logic [7:0] b);
    rx_i   = b;
    rx_i_v = 1'b1;
    @(negedge clk);
    rx_i_v = 1'b0;
  endtask

  task automatic send_data(input logic [11:0] addr, input logic [7:0] b);
    exp_q.push_back({32'(cyc + 1), addr, b});
    send(b);
  endtask

  task automatic send_last(input logic [7:0] b, input logic [1:0] ev);
    ev_q.push_back({32'(cyc + 1), ev});
    send(b);
  endtask

  task automatic good_frame();
    send(8'hA5); send(8'h00); send(8'h03);
    send_data(12'd512, 8'h11);
    send_data(12'd513, 8'h22);
    send_data(12'd514, 8'h33);
    send_last(8'h66, EV_DONE);
  endtask

  task automatic check_reset_vals(input string name);
    check(name, 64'({we, waddr, d, cpu_hold, load_done, load_err, busy}),
          64'({1'b0, 12'd512, 8'd0, 4'b0000}));
  endtask

  // watchdog
  initial begin
    #500000;
    n_fail = n_fail + 1;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] s;
    logic [7:0] b;
    rst = 1'b1; rx_i = 8'h00; rx_i_v = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");

    // noise in IDLE
    send(8'h00); send(8'hFF); send(8'h12);
    check("noise_busy_hold", 64'({busy, cpu_hold}), 64'(2'b00));

    // good frame
    send(8'hA5);
    check("hold_after_sync", 64'({cpu_hold, busy}), 64'(2'b11));
    send(8'h00); send(8'h03);
    send_data(12'd512, 8'h11);
    send_data(12'd513, 8'h22);
    send_data(12'd514, 8'h33);
    check("hold_before_csum", 64'(cpu_hold), 64'(1));
    send_last(8'h66, EV_DONE);
    check("hold_after_done", 64'({cpu_hold, busy}), 64'(2'b00));

    // bad checksum then recovery
    send(8'hA5); send(8'h00); send(8'h03);
    send_data(12'd512, 8'h11);
    send_data(12'd513, 8'h22);
    send_data(12'd514, 8'h33);
    send_last(8'h67, EV_ERR);
    check("hold_after_bad_csum", 64'({cpu_hold, busy}), 64'(2'b10));
    good_frame();
    check("hold_cleared_by_good", 64'(cpu_hold), 64'(0));

    // length bounds
    send(8'hA5); send(8'h00); send_last(8'h00, EV_ERR);
    check("len0_state", 64'({cpu_hold, busy}), 64'(2'b10));
    send(8'hA5); send(8'h0E); send_last(8'h01, EV_ERR);
    check("len_over_state", 64'({cpu_hold, busy}), 64'(2'b10));

    // timeout: pulse appears 100 cycles after the decision window opens
    send(8'hA5); send(8'h00); send(8'h02);
    send_data(12'd512, 8'h11);
    ev_q.push_back({32'(cyc + TMO), EV_ERR});
    repeat (TMO + 5) @(negedge clk);
    check("timeout_state", 64'({cpu_hold, busy}), 64'(2'b10));

    // byte on the timeout cycle is accepted instead
    send(8'hA5); send(8'h00); send(8'h02);
    send_data(12'd512, 8'h11);
    repeat (TMO - 1) @(negedge clk);
    send_data(12'd513, 8'h22);
    check("late_byte_busy", 64'(busy), 64'(1));
    send_last(8'h33, EV_DONE);
    check("late_byte_done", 64'({cpu_hold, busy}), 64'(2'b00));

    // reset mid-DATA
    send(8'hA5); send(8'h00); send(8'h04);
    send_data(12'd512, 8'h44);
    send_data(12'd513, 8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid_frame_reset");
    repeat (3) @(negedge clk);
    good_frame();
    check("after_reset_frame", 64'({cpu_hold, busy}), 64'(2'b00));

    // maximum length, back-to-back, last write at 4095
    send(8'hA5); send(8'h0E); send(8'h00);
    s = 8'h00;
    for (int i = 0; i < 3584; i++) begin
      b = 8'(i) ^ 8'h5A;
      s = s + b;
      send_data(12'(512 + i), b);
    end
    check("max_last_waddr", 64'(waddr), 64'(4095));
    send_last(s, EV_DONE);
    check("max_done_state", 64'({cpu_hold, busy}), 64'(2'b00));

    repeat (5) @(negedge clk);
    check("write_queue_empty", 64'(exp_q.size()), 64'(0));
    check("event_queue_empty", 64'(ev_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
